// File: rtl/act_skew_feeder.sv
// rtl/act_skew_feeder.sv - skewed activation feeder with zero flush for the systolic array left edge
module act_skew_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [LEN_WIDTH-1:0]       len,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ROWS*DATA_WIDTH-1:0] in_data,
   output logic [ROWS*DATA_WIDTH-1:0] row_data,
   output logic [ROWS-1:0]            row_valid,
   output logic                       busy,
   output logic                       done
);

   localparam int FW = $clog2(ROWS + COLS) + 1;
   // Drain length: the deepest lane needs ROWS-1 extra cycles, then COLS more for the bottom row to empty.
   localparam logic [FW-1:0] FLUSH_LEN = FW'(ROWS - 1 + COLS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [LEN_WIDTH-1:0] remaining;
   logic [LEN_WIDTH-1:0] remaining_nx;
   logic [FW-1:0]        flush_cnt;
   logic [FW-1:0]        flush_cnt_nx;
   logic                 accept;

   // Control state registers; reset aborts any pass without a done pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         remaining <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nx;
         remaining <= remaining_nx;
         flush_cnt <= flush_cnt_nx;
      end
   end

   // Next-state logic and state-decoded outputs (in_ready never looks at in_valid).
   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      flush_cnt_nx = flush_cnt;
      in_ready     = 1'b0;
      busy         = (state != S_IDLE);
      done         = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_nx     = S_STREAM;
                  remaining_nx = len;
               end else begin
                  state_nx = S_DONE;
               end
            end
         end
         S_STREAM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               remaining_nx = remaining - LEN_WIDTH'(1);
               if (remaining == LEN_WIDTH'(1)) begin
                  state_nx     = S_FLUSH;
                  flush_cnt_nx = FLUSH_LEN;
               end
            end
         end
         S_FLUSH: begin
            flush_cnt_nx = flush_cnt - FW'(1);
            if (flush_cnt == FW'(1)) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   assign accept = in_valid && in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_lane
         logic [DATA_WIDTH-1:0] line_d [0:gi];
         logic                  line_v [0:gi];

         // Lane delay line shifts every cycle since the array never stalls; idle slots carry bubbles.
         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int j = 0; j <= gi; j++) begin
                  line_d[j] <= '0;
                  line_v[j] <= 1'b0;
               end
            end else begin
               line_d[0] <= accept ? in_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
               line_v[0] <= accept;
               for (int j = 1; j <= gi; j++) begin
                  line_d[j] <= line_d[j-1];
                  line_v[j] <= line_v[j-1];
               end
            end
         end

         assign row_data[gi*DATA_WIDTH +: DATA_WIDTH] = line_d[gi];
         assign row_valid[gi]                        = line_v[gi];
      end
   endgenerate

endmodule

// File: doc/act_skew_feeder.md
# act_skew_feeder

Upstream feeder for the weight-stationary systolic array of PE tiles. Accepts one activation vector per cycle over a valid/ready stream. Drives row i of the array's left edge with that vector's lane i, delayed i cycles relative to lane 0, to produce the diagonal wavefront the array needs. After the last vector it pushes zero-filled flush cycles so every partial sum drains out of the bottom row, then pulses `done`.

## Interface
- DATA_WIDTH, 8, activation width per lane; matches PE DATA_WIDTH
- ROWS, 4, array rows = vector lanes
- COLS, 4, array columns; sets drain length
- LEN_WIDTH, 16, width of the vector-count input

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- start  in  1  begin a pass; sampled only in IDLE
- len  in  LEN_WIDTH  number of vectors in the pass; sampled with start
- in_valid  in  1  in_data holds a vector
- in_ready  out  1  feeder accepts a vector this cycle
- in_data  in  ROWS*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- row_data  out  ROWS*DATA_WIDTH  skewed activations to PE data_in of column 0, row i
- row_valid  out  ROWS  lane i carries a real activation (0 = bubble/flush)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of pass

## Operation
- The array has no enable and advances every cycle, so all skew registers shift every cycle. Stalls insert bubbles instead of freezing the pipe.
- Lane i is a registered delay line of depth i+1: data = 0, valid = 0 on empty slots.
- A beat is accepted when in_valid && in_ready. Its lanes enter their delay lines with valid = 1.
- Any non-accepted cycle in STREAM or FLUSH enters data 0, valid 0 on all lanes.
- States:
  - IDLE: in_ready = 0.
    - start with len != 0: go to STREAM, remaining = len.
    - start with len = 0: go to DONE.
  - STREAM: in_ready = 1. Each accepted beat decrements remaining. When the beat with remaining = 1 is accepted, go to FLUSH with flush_cnt = ROWS-1+COLS.
  - FLUSH: in_ready = 0. Zeros are pushed and flush_cnt decrements each cycle. On the cycle flush_cnt = 1, go to DONE.
  - DONE: done = 1 for exactly this cycle, then IDLE.
- start outside IDLE is ignored; len is not re-sampled.
- Widths: remaining and flush_cnt are unsigned. flush_cnt width is clog2(ROWS+COLS)+1. No wrap: len up to 2^LEN_WIDTH-1 is supported.

## Timing
- Reset (rst = 0 at a rising edge): state IDLE, all delay lines cleared. row_data = 0, row_valid = 0, in_ready = 0, busy = 0, done = 0 in the following cycle. Takes priority over every other event, including mid-STREAM or mid-FLUSH; no done is issued for an aborted pass.
- start sampled in cycle s: STREAM begins at s+1, so in_ready = 1 and busy = 1 from s+1.
- Beat accepted in cycle t: lane i appears on row_data/row_valid in cycle t+1+i.
- in_ready is a function of state only, not of in_valid.
- The last beat is accepted in cycle L: FLUSH covers L+1 .. L+ROWS-1+COLS, and done is high in cycle L+ROWS+COLS.
- len = 0: done is high in cycle s+1 and busy is high only in that cycle.
- After DONE, IDLE accepts a new start in the very next cycle.

## Test plan
(ROWS = 4, COLS = 4, DATA_WIDTH = 8)
- **Reset:** hold rst = 0 for 2 cycles with random inputs -> row_data = 0, row_valid = 0, in_ready = 0, busy = 0, done = 0.
- **Basic pass:** start, len = 3 at s. Drive V0 = (1,2,3,4), V1 = (5,6,7,8), V2 = (9,10,11,12) back-to-back from s+1.
  - Lane 0 shows 1, 5, 9 in s+2..s+4.
  - Lane 3 shows 4, 8, 12 in s+5..s+7.
  - in_ready falls at s+4; done is high only in s+11.
- **Bubble:** same pass with in_valid = 0 in s+2.
  - Lane 0 shows 1, 0(valid 0), 5, 9 in s+2..s+5.
  - Lane 2 shows the same pattern shifted +2.
  - done is high in s+12.
- **Zero length:** start, len = 0 -> done = 1 and busy = 1 in s+1 only. in_ready stays 0 and row_valid stays 0.
- **Ignored start:** pulse start, len = 9 during FLUSH of a len = 2 pass -> the pass ends on its original schedule and busy = 0 the cycle after done.
- **Reset mid-pass:** rst = 0 during STREAM after 1 of 3 beats -> all outputs are 0 the next cycle and no done pulse follows. A fresh start, len = 1 then completes with done at s+9.
